// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to register-file bridge in the m_clk domain.
// Command byte selects read/write and start address; data bytes auto-increment.
module spi_reg_bridge #(
  parameter int unsigned REG_N       = 8,
  parameter logic [7:0]  ID_BYTE     = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               m_clk,
  input  logic               rst,
  input  logic               csn_pad,
  input  logic               spi_drdy,
  input  logic [7:0]         spi_rx_byte,
  output logic [7:0]         spi_tx_byte,
  output logic               reg_wr_stb,
  output logic [6:0]         reg_wr_addr,
  output logic [7:0]         reg_wr_data,
  output logic [REG_N*8-1:0] regs_flat
);

  localparam logic [7:0] REG_LIM = 8'(REG_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WR,
    S_RD
  } state_e;

  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] drdy_sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   drdy_prev_q;
  logic                   armed_q, armed_d;
  logic                   csn_s, drdy_s, byte_evt;

  state_e     state_q, state_d;
  logic [6:0] ptr_q, ptr_d;
  logic [7:0] tx_q, tx_d;
  logic       stb_q, stb_d;
  logic [6:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wr_en;

  logic [7:0] regs_q [REG_N];
  logic [7:0] rd_tab [128];

  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign drdy_s   = drdy_sync_q[SYNC_STAGES-1];
  assign byte_evt = drdy_s & ~drdy_prev_q;

  // vld_q marks when csn_s carries a real pad sample rather than the
  // reset fill; only a genuine high csn arms the FSM after reset.
  assign armed_d = armed_q | (csn_s & vld_q[SYNC_STAGES-1]);

  always_ff @(posedge m_clk) begin
    if (rst) begin
      csn_sync_q  <= '1;
      drdy_sync_q <= '0;
      vld_q       <= '0;
      drdy_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_pad};
      drdy_sync_q <= {drdy_sync_q[SYNC_STAGES-2:0], spi_drdy};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      drdy_prev_q <= drdy_s;
      armed_q     <= armed_d;
    end
  end

  for (genvar k = 0; k < 128; k++) begin : g_rd
    if (k < REG_N) begin : g_on
      assign rd_tab[k] = regs_q[k];
    end else begin : g_off
      assign rd_tab[k] = 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    stb_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wr_en   = 1'b0;
    if (csn_s) begin
      state_d = S_IDLE;
      tx_d    = ID_BYTE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tx_d = ID_BYTE;
          if (armed_q) state_d = S_CMD;
        end
        S_CMD: begin
          if (byte_evt) begin
            if (spi_rx_byte[7]) begin
              ptr_d   = spi_rx_byte[6:0];
              tx_d    = 8'h00;
              state_d = S_WR;
            end else begin
              tx_d    = rd_tab[spi_rx_byte[6:0]];
              ptr_d   = spi_rx_byte[6:0] + 7'd1;
              state_d = S_RD;
            end
          end
        end
        S_WR: begin
          tx_d = 8'h00;
          if (byte_evt) begin
            ptr_d = ptr_q + 7'd1;
            if ({1'b0, ptr_q} < REG_LIM) begin
              wr_en   = 1'b1;
              stb_d   = 1'b1;
              waddr_d = ptr_q;
              wdata_d = spi_rx_byte;
            end
          end
        end
        S_RD: begin
          if (byte_evt) begin
            tx_d  = rd_tab[ptr_q];
            ptr_d = ptr_q + 7'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge m_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      tx_q    <= ID_BYTE;
      stb_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      stb_q   <= stb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge m_clk) begin
    if (rst) begin
      for (int k = 0; k < REG_N; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < REG_N; k++) begin
        if (wr_en && ptr_q == 7'(k)) regs_q[k] <= spi_rx_byte;
      end
    end
  end

  for (genvar k = 0; k < REG_N; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = regs_q[k];
  end

  assign spi_tx_byte = tx_q;
  assign reg_wr_stb  = stb_q;
  assign reg_wr_addr = waddr_q;
  assign reg_wr_data = wdata_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: byte-level SPI peripheral emulation
// against an address/array model of the register protocol.
module tb_spi_reg_bridge;

  localparam int         REG_N = 8;
  localparam logic [7:0] ID    = 8'hA5;

  logic               m_clk = 1'b0;
  logic               rst;
  logic               csn_pad;
  logic               spi_drdy;
  logic [7:0]         spi_rx_byte;
  logic [7:0]         spi_tx_byte;
  logic               reg_wr_stb;
  logic [6:0]         reg_wr_addr;
  logic [7:0]         reg_wr_data;
  logic [REG_N*8-1:0] regs_flat;

  spi_reg_bridge #(
    .REG_N(REG_N),
    .ID_BYTE(ID),
    .SYNC_STAGES(2)
  ) dut (
    .m_clk(m_clk),
    .rst(rst),
    .csn_pad(csn_pad),
    .spi_drdy(spi_drdy),
    .spi_rx_byte(spi_rx_byte),
    .spi_tx_byte(spi_tx_byte),
    .reg_wr_stb(reg_wr_stb),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .regs_flat(regs_flat)
  );

  always #5 m_clk = ~m_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [128];
  logic [7:0]  tb_b [8];
  logic [14:0] obs_q [$];
  logic [14:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] flat_byte(input int a);
    logic [REG_N*8-1:0] t;
    t = regs_flat >> (8 * a);
    return t[7:0];
  endfunction

  function automatic logic [7:0] rd_ref(input logic [6:0] a);
    return (int'(a) < REG_N) ? mem[a] : 8'h00;
  endfunction

  always @(negedge m_clk) begin
    if (reg_wr_stb) begin
      obs_q.push_back({reg_wr_addr, reg_wr_data});
      check_eq("flat_at_stb", 32'(flat_byte(int'(reg_wr_addr))),
               32'(reg_wr_data));
    end
  end

  // Byte i: boundary load, drdy drop at 1st SCK rise, data + drdy at 8th
  // rise (600 ns in), next boundary 40 ns later. SCK period 80 ns.
  task automatic xfer(input int n, input int abort_at, input int rst_at);
    logic [6:0] a;
    logic [6:0] wa;
    logic       wr;
    bit         dead;
    logic [7:0] e;
    a    = '0;
    wr   = 1'b0;
    dead = 0;
    obs_q.delete();
    exp_q.delete();
    csn_pad = 1'b0;
    #100;
    for (int i = 0; i < n; i++) begin
      if (dead || i == 0) e = ID;
      else if (wr) e = 8'h00;
      else e = rd_ref(a + 7'(i - 1));
      check_eq("miso", 32'(spi_tx_byte), 32'(e));
      #40 spi_drdy = 1'b0;
      if (i == abort_at) begin
        #240;
        break;
      end
      #560;
      spi_rx_byte = tb_b[i];
      spi_drdy    = 1'b1;
      if (!dead) begin
        if (i == 0) begin
          wr = tb_b[0][7];
          a  = tb_b[0][6:0];
        end else if (wr) begin
          wa = a + 7'(i - 1);
          if (int'(wa) < REG_N) begin
            mem[wa] = tb_b[i];
            exp_q.push_back({wa, tb_b[i]});
          end
        end
      end
      #40;
      if (i == rst_at) begin
        @(negedge m_clk) rst = 1'b1;
        @(negedge m_clk) rst = 1'b0;
        dead = 1;
        for (int k = 0; k < 128; k++) mem[k] = 8'h00;
        check_eq("rst_tx", 32'(spi_tx_byte), 32'(ID));
      end
    end
    #100 csn_pad = 1'b1;
    #150;
    check_eq("n_stb", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check_eq("stb", 32'(obs_q[i]), 32'(exp_q[i]));
    end
    for (int k = 0; k < REG_N; k++) check_eq("reg", 32'(flat_byte(k)), 32'(mem[k]));
  endtask

  task automatic set4(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    tb_b[0] = b0;
    tb_b[1] = b1;
    tb_b[2] = b2;
    tb_b[3] = b3;
  endtask

  initial begin
    int n;
    int ab;
    logic       wr;
    logic [6:0] a;
    for (int k = 0; k < 128; k++) mem[k] = 8'h00;
    for (int k = 0; k < 8; k++) tb_b[k] = 8'h00;
    rst         = 1'b1;
    csn_pad     = 1'b1;
    spi_drdy    = 1'b0;
    spi_rx_byte = 8'h00;
    repeat (4) @(posedge m_clk);
    @(negedge m_clk);
    check_eq("rst_tx_byte", 32'(spi_tx_byte), 32'(ID));
    check_eq("rst_stb", 32'(reg_wr_stb), 32'(0));
    check_eq("rst_addr", 32'(reg_wr_addr), 32'(0));
    check_eq("rst_data", 32'(reg_wr_data), 32'(0));
    check_eq("rst_flat", 32'(regs_flat[31:0]), 32'(0));
    rst = 1'b0;
    #100;

    set4(8'h00, 8'h00, 8'h00, 8'h00);
    xfer(4, -1, -1);
    set4(8'h82, 8'h11, 8'h22, 8'h00);
    xfer(3, -1, -1);
    check_eq("flat_23_16", 32'(regs_flat[23:16]), 32'h11);
    set4(8'h02, 8'h5A, 8'h5A, 8'h00);
    xfer(3, -1, -1);
    set4(8'hFF, 8'hAA, 8'hBB, 8'h00);
    xfer(3, -1, -1);
    set4(8'h84, 8'h77, 8'h00, 8'h00);
    xfer(2, 1, -1);
    set4(8'h00, 8'h00, 8'h00, 8'h00);
    xfer(4, -1, -1);
    set4(8'h02, 8'h00, 8'h00, 8'h00);
    xfer(4, -1, 1);
    set4(8'h00, 8'h00, 8'h00, 8'h00);
    xfer(4, -1, -1);

    repeat (25) begin
      n  = $urandom_range(1, 6);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(120, 127));
      else a = 7'($urandom_range(0, REG_N + 1));
      tb_b[0] = {wr, a};
      for (int k = 1; k < 8; k++) tb_b[k] = 8'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      xfer(n, ab, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- System-clock (m_clk) consumer of the mode-0 SPI byte peripheral. Takes its DRDY/received byte and supplies its next transmit byte.
- Synchronises the SCK-domain handshake into m_clk and decodes a command/data byte protocol.
- Maintains a small byte register file that the SPI host can write and read, with auto-incrementing addresses.
- Exposes the register contents and a write strobe to fabric logic.

Parameters:
- REG_N, 8, number of implemented 8-bit registers (1..128).
- ID_BYTE, 8'hA5, byte presented on spi_tx_byte while idle, i.e. the first byte shifted out in every transaction.
- SYNC_STAGES, 2, flip-flop depth of the csn/drdy synchronisers (>=2).

Ports:
- m_clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- csn_pad  in  1  SPI chip select, asynchronous, active low.
- spi_drdy  in  1  byte-ready from the SPI peripheral, SCK domain, asynchronous to m_clk.
- spi_rx_byte  in  8  received byte from the SPI peripheral, stable while spi_drdy is high.
- spi_tx_byte  out  8  next byte to transmit; drives the peripheral's d_to_send.
- reg_wr_stb  out  1  one-cycle pulse per SPI register write.
- reg_wr_addr  out  7  address of the write.
- reg_wr_data  out  8  data of the write.
- regs_flat  out  REG_N*8  all registers; reg k occupies bits [8k+7:8k].

Behaviour:
- Reset (rst high at a m_clk edge):
  - all registers = 0; spi_tx_byte = ID_BYTE; reg_wr_stb = 0; reg_wr_addr = 0; reg_wr_data = 0.
  - FSM = IDLE; address pointer = 0; synchronisers cleared, with csn treated as high.
- Synchronisation: csn_pad and spi_drdy each pass through SYNC_STAGES flops.
  - byte_evt = one-cycle pulse on the rising edge of synced drdy.
  - spi_rx_byte is sampled on the byte_evt cycle without its own synchroniser. It is stable by then.
- Timing constraint: SCK <= m_clk/8.
  - spi_tx_byte must settle within SYNC_STAGES+2 m_clk cycles of the 8th SCK rising edge.
  - That is before the peripheral's next byte-boundary load.
- FSM states:
  - IDLE: spi_tx_byte = ID_BYTE. Go to CMD when synced csn is low.
  - CMD: on byte_evt, cmd = spi_rx_byte. Bit7: 1 = write, 0 = read. ptr = cmd[6:0].
    - Write command: go to WR.
    - Read command: load spi_tx_byte = rd(ptr), increment ptr, go to RD.
  - WR: on byte_evt, if ptr < REG_N then reg[ptr] = spi_rx_byte.
    - Also pulse reg_wr_stb with reg_wr_addr = ptr and reg_wr_data = byte; this happens in the next cycle.
    - Then increment ptr. spi_tx_byte = 8'h00 throughout WR.
  - RD: on byte_evt, received byte is ignored; spi_tx_byte = rd(ptr); increment ptr.
- rd(a) = reg[a] if a < REG_N, else 8'h00.
- Writes to a >= REG_N are dropped: no register change and no strobe.
- ptr is 7 bits and wraps from 127 to 0.
- Synced csn high from any state → IDLE in the same cycle. Any byte_evt in that cycle is ignored, so a partial transaction is aborted and completed writes are kept.
- A byte_evt seen in IDLE is ignored. This covers the peripheral's stale DRDY left high from the prior transaction, which the rising-edge detection already filters.
- rst asserted mid-transaction: immediate return to reset state. Bytes still in flight are ignored until csn is seen high, then low again.
- Write strobe vs regs_flat: the register update and regs_flat change occur in the same cycle as reg_wr_stb.

Test Plan:
- Reset, then read with CS low and host sending 8'h00 followed by 3 dummy bytes.
  - MISO returns A5, reg0, reg1, reg2 = A5, 00, 00, 00.
- Write sequence 0x82, 0x11, 0x22.
  - reg2 = 0x11, reg3 = 0x22.
  - Two reg_wr_stb pulses with addr 2 and 3.
  - regs_flat[23:16] = 0x11.
- Read back with 0x02 followed by 2 dummy bytes.
  - MISO = A5, 11, 22.
- Write 0xFF, 0xAA, 0xBB (ptr starts at 127, wraps to 0) with REG_N = 8.
  - Address 127 write dropped with no strobe.
  - reg0 = 0xBB, with a strobe at addr 0.
- Raise CS after 4 SCK bits of a data byte in WR, then start a new read transaction.
  - No write occurs and the FSM returns to IDLE.
  - Next transaction starts with A5 and a fresh command.
- Assert rst for 1 cycle mid-RD.
  - All registers become 0 and spi_tx_byte = A5.
  - Following bytes are ignored until CS cycles.
